// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 host-side blocks: FSM states, default timing
// constants and the frame parity helper.
package ps2_pkg;

    localparam int unsigned PS2_CLK_DIV       = 250;
    localparam int unsigned PS2_INHIBIT_TICKS = 24;
    localparam int unsigned PS2_TIMEOUT_TICKS = 4000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INHIBIT,
        ST_REQ,
        ST_SHIFT,
        ST_ACK,
        ST_WAIT_IDLE,
        ST_DONE
    } ps2_state_t;

    // PS/2 frames carry odd parity: data bits plus parity hold an odd count of ones.
    function automatic logic odd_parity(input logic [7:0] i_byte);
        return ~^i_byte;
    endfunction

endpackage

// File: rtl/ps2_line_sampler.sv
// Tick divider, pad synchronizers and tick-resolution PS2_CLK falling-edge strobe.
// The level outputs are the synchronized pad values; consumers only look at them on o_tick.
module ps2_line_sampler
    import ps2_pkg::*;
#(
    parameter int unsigned CLK_DIV = PS2_CLK_DIV
) (
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic i_ps2_clk_in,
    input  logic i_ps2_data_in,
    output logic o_tick,
    output logic o_clk_lvl,
    output logic o_data_lvl,
    output logic o_clk_fall
);

    localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DW-1:0] r_div;
    logic [1:0]    r_clk_sync;
    logic [1:0]    r_data_sync;
    logic          r_clk_prev;
    logic          w_tick;

    assign w_tick = (r_div == '0);

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_div       <= '0;
            r_clk_sync  <= 2'b11;
            r_data_sync <= 2'b11;
            r_clk_prev  <= 1'b1;
        end else begin
            r_clk_sync  <= {r_clk_sync[0], i_ps2_clk_in};
            r_data_sync <= {r_data_sync[0], i_ps2_data_in};
            if (w_tick) begin
                r_div      <= DW'(CLK_DIV - 1);
                r_clk_prev <= r_clk_sync[1];
            end else begin
                r_div <= r_div - 1'b1;
            end
        end
    end

    assign o_tick     = w_tick;
    assign o_clk_lvl  = r_clk_sync[1];
    assign o_data_lvl = r_data_sync[1];
    // Previous tick saw the clock high, this tick sees it low.
    assign o_clk_fall = w_tick & r_clk_prev & ~r_clk_sync[1];

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibits the bus, issues a request-to-send and
// shifts one command byte out on device-generated clock edges, then checks the ACK.
//   state      | meaning
//   IDLE       | lines released, ready for a byte
//   INHIBIT    | PS2_CLK held low for INHIBIT_TICKS ticks
//   REQ        | start bit driven with clock still low, one tick
//   SHIFT      | data/parity/stop driven on device falling edges 1..10
//   ACK        | edge 11 samples the device ACK on PS2_DATA
//   WAIT_IDLE  | wait for both lines high
//   DONE       | one-cycle TX_DONE pulse
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int unsigned CLK_DIV       = PS2_CLK_DIV,
    parameter int unsigned INHIBIT_TICKS = PS2_INHIBIT_TICKS,
    parameter int unsigned TIMEOUT_TICKS = PS2_TIMEOUT_TICKS
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic [7:0] i_tx_data,
    input  logic       i_tx_valid,
    output logic       o_tx_ready,
    output logic       o_tx_busy,
    output logic       o_tx_done,
    output logic       o_tx_err,
    input  logic       i_ps2_clk_in,
    input  logic       i_ps2_data_in,
    output logic       o_ps2_clk_oe,
    output logic       o_ps2_data_oe
);

    localparam int unsigned TMAX = (TIMEOUT_TICKS > INHIBIT_TICKS) ? TIMEOUT_TICKS : INHIBIT_TICKS;
    localparam int unsigned TW   = $clog2(TMAX + 1);

    ps2_state_t    r_state,   w_state_nxt;
    logic [9:0]    r_frame,   w_frame_nxt;
    logic [3:0]    r_bit_cnt, w_bit_cnt_nxt;
    logic [TW-1:0] r_timer,   w_timer_nxt;
    logic          r_clk_oe,  w_clk_oe_nxt;
    logic          r_data_oe, w_data_oe_nxt;
    logic          r_err,     w_err_nxt;

    logic w_tick;
    logic w_clk_lvl;
    logic w_data_lvl;
    logic w_clk_fall;
    logic w_expired;

    ps2_line_sampler #(
        .CLK_DIV (CLK_DIV)
    ) u_sampler (
        .i_clk         (i_clk),
        .i_reset_n     (i_reset_n),
        .i_ps2_clk_in  (i_ps2_clk_in),
        .i_ps2_data_in (i_ps2_data_in),
        .o_tick        (w_tick),
        .o_clk_lvl     (w_clk_lvl),
        .o_data_lvl    (w_data_lvl),
        .o_clk_fall    (w_clk_fall)
    );

    assign w_expired = w_tick && (r_timer <= TW'(1));

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_state   <= ST_IDLE;
            r_frame   <= '0;
            r_bit_cnt <= '0;
            r_timer   <= '0;
            r_clk_oe  <= 1'b0;
            r_data_oe <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_frame   <= w_frame_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_timer   <= w_timer_nxt;
            r_clk_oe  <= w_clk_oe_nxt;
            r_data_oe <= w_data_oe_nxt;
            r_err     <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_frame_nxt   = r_frame;
        w_bit_cnt_nxt = r_bit_cnt;
        w_timer_nxt   = r_timer;
        w_clk_oe_nxt  = r_clk_oe;
        w_data_oe_nxt = r_data_oe;
        w_err_nxt     = r_err;

        case (r_state)
            ST_IDLE: begin
                w_clk_oe_nxt  = 1'b0;
                w_data_oe_nxt = 1'b0;
                if (i_tx_valid) begin
                    w_frame_nxt  = {1'b1, odd_parity(i_tx_data), i_tx_data};
                    w_err_nxt    = 1'b0;
                    w_clk_oe_nxt = 1'b1;
                    w_timer_nxt  = TW'(INHIBIT_TICKS);
                    w_state_nxt  = ST_INHIBIT;
                end
            end
            ST_INHIBIT: begin
                if (w_expired) begin
                    w_data_oe_nxt = 1'b1;
                    w_timer_nxt   = TW'(TIMEOUT_TICKS);
                    w_state_nxt   = ST_REQ;
                end else if (w_tick) begin
                    w_timer_nxt = r_timer - 1'b1;
                end
            end
            ST_REQ: begin
                if (w_tick) begin
                    w_clk_oe_nxt  = 1'b0;
                    w_bit_cnt_nxt = '0;
                    w_timer_nxt   = TW'(TIMEOUT_TICKS);
                    w_state_nxt   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                // Frame bit 9 is the stop bit (1), so edge 10 releases the data line.
                if (w_clk_fall) begin
                    w_data_oe_nxt = ~r_frame[r_bit_cnt];
                    w_bit_cnt_nxt = r_bit_cnt + 4'd1;
                    w_timer_nxt   = TW'(TIMEOUT_TICKS);
                    if (r_bit_cnt == 4'd9) begin
                        w_state_nxt = ST_ACK;
                    end
                end else if (w_expired) begin
                    w_clk_oe_nxt  = 1'b0;
                    w_data_oe_nxt = 1'b0;
                    w_err_nxt     = 1'b1;
                    w_state_nxt   = ST_DONE;
                end else if (w_tick) begin
                    w_timer_nxt = r_timer - 1'b1;
                end
            end
            ST_ACK: begin
                if (w_clk_fall) begin
                    w_err_nxt   = w_data_lvl;
                    w_timer_nxt = TW'(TIMEOUT_TICKS);
                    w_state_nxt = ST_WAIT_IDLE;
                end else if (w_expired) begin
                    w_clk_oe_nxt  = 1'b0;
                    w_data_oe_nxt = 1'b0;
                    w_err_nxt     = 1'b1;
                    w_state_nxt   = ST_DONE;
                end else if (w_tick) begin
                    w_timer_nxt = r_timer - 1'b1;
                end
            end
            ST_WAIT_IDLE: begin
                if (w_tick && w_clk_lvl && w_data_lvl) begin
                    w_state_nxt = ST_DONE;
                end else if (w_clk_fall) begin
                    w_timer_nxt = TW'(TIMEOUT_TICKS);
                end else if (w_expired) begin
                    w_clk_oe_nxt  = 1'b0;
                    w_data_oe_nxt = 1'b0;
                    w_err_nxt     = 1'b1;
                    w_state_nxt   = ST_DONE;
                end else if (w_tick) begin
                    w_timer_nxt = r_timer - 1'b1;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_clk_oe_nxt  = 1'b0;
                w_data_oe_nxt = 1'b0;
                w_state_nxt   = ST_IDLE;
            end
        endcase
    end

    assign o_tx_ready    = (r_state == ST_IDLE);
    assign o_tx_busy     = (r_state != ST_IDLE);
    assign o_tx_done     = (r_state == ST_DONE);
    assign o_tx_err      = r_err;
    assign o_ps2_clk_oe  = r_clk_oe;
    assign o_ps2_data_oe = r_data_oe;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a behavioural PS/2 device clocking at
// 10 ticks per period (20 board clocks per half period at CLK_DIV=4).
module tb_ps2_host_tx;

    localparam int CLK_DIV = 4;
    localparam int INH     = 3;
    localparam int TMO     = 50;
    localparam int HALF    = 20;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready, tx_busy, tx_done, tx_err;
    logic       clk_oe, data_oe;
    logic       dev_clk_low, dev_data_low;
    logic       ps2_clk_line, ps2_data_line;

    int n_checks = 0;
    int n_pass   = 0;

    logic [9:0] dev_bits;
    int         dev_edges;

    logic       o_lat_oe, o_lat_busy, o_req;
    int         o_inh, o_cyc;
    logic       o_seen, o_err, o_post_done, o_post_ready;
    logic [1:0] o_oes;

    always #5 clk = ~clk;

    assign ps2_clk_line  = ~(clk_oe | dev_clk_low);
    assign ps2_data_line = ~(data_oe | dev_data_low);

    ps2_host_tx #(
        .CLK_DIV       (CLK_DIV),
        .INHIBIT_TICKS (INH),
        .TIMEOUT_TICKS (TMO)
    ) dut (
        .i_clk         (clk),
        .i_reset_n     (rst_n),
        .i_tx_data     (tx_data),
        .i_tx_valid    (tx_valid),
        .o_tx_ready    (tx_ready),
        .o_tx_busy     (tx_busy),
        .o_tx_done     (tx_done),
        .o_tx_err      (tx_err),
        .i_ps2_clk_in  (ps2_clk_line),
        .i_ps2_data_in (ps2_data_line),
        .o_ps2_clk_oe  (clk_oe),
        .o_ps2_data_oe (data_oe)
    );

    // Device: waits for request-to-send, clocks edges 1..last_edge, samples on rising edges.
    task automatic device(input bit ack, input int last_edge);
        int guard;
        dev_bits  = '0;
        dev_edges = 0;
        guard     = 0;
        while (!(clk_oe == 1'b0 && data_oe == 1'b1) && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        if (guard < 500) begin
            repeat (HALF) @(negedge clk);
            for (int e = 1; e <= last_edge; e++) begin
                dev_clk_low = 1'b1;
                dev_edges   = e;
                repeat (HALF) @(negedge clk);
                if (e <= 10) dev_bits[e-1] = ps2_data_line;
                dev_clk_low = 1'b0;
                if (e == 10 && ack) dev_data_low = 1'b1;
                if (e == 11) dev_data_low = 1'b0;
                repeat (HALF) @(negedge clk);
            end
        end
    endtask

    task automatic do_accept(input logic [7:0] d, input bit keep);
        @(negedge clk);
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge clk);
        o_lat_oe   = clk_oe;
        o_lat_busy = tx_busy;
        if (!keep) tx_valid = 1'b0;
    endtask

    task automatic do_inhibit();
        o_inh = 0;
        while (clk_oe && !data_oe && o_inh < 100) begin
            o_inh++;
            @(negedge clk);
        end
        o_req = clk_oe & data_oe;
    endtask

    task automatic do_wait_done();
        o_cyc = 0;
        while (!tx_done && o_cyc < 3000) begin
            @(negedge clk);
            o_cyc++;
        end
        o_seen = tx_done;
        o_err  = tx_err;
        o_oes  = {clk_oe, data_oe};
        @(negedge clk);
        o_post_done  = tx_done;
        o_post_ready = tx_ready;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if ({clk_oe, data_oe} !== 2'b00) $display("FAIL reset_oes: got %b expected 00", {clk_oe, data_oe}); else n_pass++;
        n_checks++; if (tx_ready !== 1'b1) $display("FAIL reset_ready: got %b expected 1", tx_ready); else n_pass++;
        n_checks++; if (tx_busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", tx_busy); else n_pass++;
        n_checks++; if (tx_done !== 1'b0) $display("FAIL reset_done: got %b expected 0", tx_done); else n_pass++;
        n_checks++; if (tx_err !== 1'b0) $display("FAIL reset_err: got %b expected 0", tx_err); else n_pass++;
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_send_ed();
        fork
            device(1'b1, 11);
            begin
                do_accept(8'hED, 1'b0);
                do_inhibit();
                do_wait_done();
            end
        join
        n_checks++; if (o_lat_oe !== 1'b1 || o_lat_busy !== 1'b1) $display("FAIL ed_accept_latency: got oe=%b busy=%b expected 1 1", o_lat_oe, o_lat_busy); else n_pass++;
        n_checks++; if (o_inh < 9 || o_inh > 12) $display("FAIL ed_inhibit_cycles: got %0d expected 9..12", o_inh); else n_pass++;
        n_checks++; if (o_req !== 1'b1) $display("FAIL ed_start_bit: got %b expected 1", o_req); else n_pass++;
        n_checks++; if (dev_bits !== 10'h3ED) $display("FAIL ed_frame: got %h expected 3ed", dev_bits); else n_pass++;
        n_checks++; if (o_seen !== 1'b1) $display("FAIL ed_done: got %b expected 1", o_seen); else n_pass++;
        n_checks++; if (o_err !== 1'b0) $display("FAIL ed_err: got %b expected 0", o_err); else n_pass++;
        n_checks++; if (o_oes !== 2'b00) $display("FAIL ed_oes: got %b expected 00", o_oes); else n_pass++;
        n_checks++; if (o_post_done !== 1'b0) $display("FAIL ed_done_width: got %b expected 0", o_post_done); else n_pass++;
        n_checks++; if (o_post_ready !== 1'b1) $display("FAIL ed_ready_after: got %b expected 1", o_post_ready); else n_pass++;
    endtask

    task automatic test_parity();
        fork
            device(1'b1, 11);
            begin do_accept(8'h00, 1'b0); do_wait_done(); end
        join
        n_checks++; if (dev_bits !== 10'h300) $display("FAIL par00_frame: got %h expected 300", dev_bits); else n_pass++;
        n_checks++; if (o_seen !== 1'b1 || o_err !== 1'b0) $display("FAIL par00_done_err: got done=%b err=%b expected 1 0", o_seen, o_err); else n_pass++;
        fork
            device(1'b1, 11);
            begin do_accept(8'h01, 1'b0); do_wait_done(); end
        join
        n_checks++; if (dev_bits !== 10'h201) $display("FAIL par01_frame: got %h expected 201", dev_bits); else n_pass++;
        n_checks++; if (o_seen !== 1'b1 || o_err !== 1'b0) $display("FAIL par01_done_err: got done=%b err=%b expected 1 0", o_seen, o_err); else n_pass++;
    endtask

    task automatic test_no_ack();
        fork
            device(1'b0, 11);
            begin do_accept(8'h5A, 1'b0); do_wait_done(); end
        join
        n_checks++; if (o_seen !== 1'b1) $display("FAIL noack_done: got %b expected 1", o_seen); else n_pass++;
        n_checks++; if (o_err !== 1'b1) $display("FAIL noack_err: got %b expected 1", o_err); else n_pass++;
        n_checks++; if (o_oes !== 2'b00) $display("FAIL noack_oes: got %b expected 00", o_oes); else n_pass++;
        n_checks++; if (tx_err !== 1'b1) $display("FAIL noack_err_held: got %b expected 1", tx_err); else n_pass++;
    endtask

    task automatic test_timeout();
        int g;
        do_accept(8'h55, 1'b0);
        g = 0;
        while (!(clk_oe == 1'b0 && data_oe == 1'b1) && g < 300) begin
            @(negedge clk);
            g++;
        end
        do_wait_done();
        n_checks++; if (o_cyc !== TMO * CLK_DIV) $display("FAIL tmo_cycles: got %0d expected %0d", o_cyc, TMO * CLK_DIV); else n_pass++;
        n_checks++; if (o_err !== 1'b1) $display("FAIL tmo_err: got %b expected 1", o_err); else n_pass++;
        n_checks++; if (o_oes !== 2'b00) $display("FAIL tmo_oes: got %b expected 00", o_oes); else n_pass++;
    endtask

    task automatic test_reset_midframe();
        int done_cnt;
        int g;
        logic [1:0] oes_r;
        logic ready_r, done_r;
        done_cnt = 0;
        fork
            device(1'b1, 5);
            begin
                do_accept(8'h96, 1'b0);
                g = 0;
                while (dev_edges < 5 && g < 1000) begin
                    @(negedge clk);
                    if (tx_done) done_cnt++;
                    g++;
                end
                repeat (8) begin
                    @(negedge clk);
                    if (tx_done) done_cnt++;
                end
                rst_n = 1'b0;
                @(negedge clk);
                oes_r   = {clk_oe, data_oe};
                ready_r = tx_ready;
                done_r  = tx_done;
                rst_n   = 1'b1;
                repeat (40) begin
                    @(negedge clk);
                    if (tx_done) done_cnt++;
                end
            end
        join
        n_checks++; if (g >= 1000) $display("FAIL rst_edge5_seen: got timeout expected edge 5"); else n_pass++;
        n_checks++; if (oes_r !== 2'b00) $display("FAIL rst_oes: got %b expected 00", oes_r); else n_pass++;
        n_checks++; if (ready_r !== 1'b1) $display("FAIL rst_ready: got %b expected 1", ready_r); else n_pass++;
        n_checks++; if (done_r !== 1'b0 || done_cnt != 0) $display("FAIL rst_no_done: got done=%b count=%0d expected 0 0", done_r, done_cnt); else n_pass++;
        fork
            device(1'b1, 11);
            begin do_accept(8'hFF, 1'b0); do_wait_done(); end
        join
        n_checks++; if (dev_bits !== 10'h3FF) $display("FAIL rst_ff_frame: got %h expected 3ff", dev_bits); else n_pass++;
        n_checks++; if (o_seen !== 1'b1 || o_err !== 1'b0) $display("FAIL rst_ff_done_err: got done=%b err=%b expected 1 0", o_seen, o_err); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic second_oe;
        fork
            device(1'b1, 11);
            begin
                do_accept(8'h3C, 1'b1);
                do_inhibit();
                repeat (60) @(negedge clk);
                tx_data = 8'hA5;
                do_wait_done();
                @(negedge clk);
                second_oe = clk_oe & tx_busy;
                tx_valid  = 1'b0;
            end
        join
        n_checks++; if (dev_bits !== 10'h33C) $display("FAIL b2b_first_frame: got %h expected 33c", dev_bits); else n_pass++;
        n_checks++; if (o_seen !== 1'b1 || o_err !== 1'b0) $display("FAIL b2b_first_done: got done=%b err=%b expected 1 0", o_seen, o_err); else n_pass++;
        n_checks++; if (o_post_ready !== 1'b1) $display("FAIL b2b_ready_after: got %b expected 1", o_post_ready); else n_pass++;
        n_checks++; if (second_oe !== 1'b1) $display("FAIL b2b_second_accept: got %b expected 1", second_oe); else n_pass++;
        fork
            device(1'b1, 11);
            do_wait_done();
        join
        n_checks++; if (dev_bits !== 10'h3A5) $display("FAIL b2b_second_frame: got %h expected 3a5", dev_bits); else n_pass++;
        n_checks++; if (o_seen !== 1'b1 || o_err !== 1'b0) $display("FAIL b2b_second_done: got done=%b err=%b expected 1 0", o_seen, o_err); else n_pass++;
        repeat (5) @(negedge clk);
        n_checks++; if (tx_ready !== 1'b1) $display("FAIL b2b_no_third: got ready=%b expected 1", tx_ready); else n_pass++;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tx_data      = 8'h00;
        tx_valid     = 1'b0;
        dev_clk_low  = 1'b0;
        dev_data_low = 1'b0;
        rst_n        = 1'b0;
        test_reset();
        test_send_ed();
        test_parity();
        test_no_ack();
        test_timeout();
        test_reset_midframe();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
